execute_result_collect: RTL
===========================

Name: execute_result_collect

Overview:
Execute-stage result sink and issue sequencer that sits on the consuming end of the execute-unit interface. Upstream operand read drives read_valid to all execute units in parallel. Each unit answers with processing/valid/rd_val. This block tracks the instruction in flight, waits on multi-cycle units such as the iterative shifter, registers the single result, and offers it to register-file writeback with a valid/ready handshake. It also stalls upstream and flags illegal ops, timeouts and protocol errors.

Parameters:
NUM_UNITS, 4, number of execute units on the result bus; index 0 has highest priority
TIMEOUT_CYCLES, 64, maximum cycles allowed in BUSY before abort (1..255)

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush; discards in-flight instruction
read_valid  input  1  operands presented to the execute units this cycle
decode_rd  input  5  destination register of the instruction issued with read_valid
unit_processing  input  NUM_UNITS  per-unit processing flag
unit_valid  input  NUM_UNITS  per-unit result-valid flag
unit_rd_val  input  32*NUM_UNITS  per-unit results; unit i occupies bits [32*i+31:32*i]
exec_busy  output  1  upstream must not assert read_valid
wb_valid  output  1  writeback result available
wb_ready  input  1  writeback accepts the result
wb_rd  output  5  destination register
wb_val  output  32  result value
illegal_op  output  1  one-cycle pulse: no unit claimed the issued op
timeout  output  1  one-cycle pulse: BUSY exceeded TIMEOUT_CYCLES
protocol_err  output  1  sticky error flag
retired_count  output  32  count of accepted writebacks

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0: state=IDLE, and exec_busy, wb_valid, illegal_op, timeout, protocol_err, wb_rd, wb_val, retired_count and the timeout counter are all 0. Reset mid-operation discards everything.
- States are IDLE, BUSY and RESULT. exec_busy is 1 when state != IDLE. exec_busy is registered, so it does not depend combinationally on read_valid.
- The winning unit is the lowest-index set bit of unit_valid. If more than one unit_valid bit is set in a capture cycle, protocol_err is set.
- IDLE, read_valid=1, flush=0:
  - Latch decode_rd into rd_reg.
  - If any unit_valid bit is set: latch the winning unit_rd_val and go to RESULT. Latency for a single-cycle unit is wb_valid high on the cycle after read_valid.
  - Otherwise, if any unit_processing bit is set: go to BUSY and clear the timeout counter.
  - Otherwise: pulse illegal_op on the next cycle and stay in IDLE.
- BUSY:
  - The timeout counter increments every cycle.
  - When any unit_valid bit is set, latch the winning result and go to RESULT.
  - If the counter reaches TIMEOUT_CYCLES with no unit_valid, pulse timeout and go to IDLE. No writeback occurs.
- RESULT:
  - wb_valid=1 and wb_rd=rd_reg.
  - wb_val is the latched value, forced to 0 when rd_reg=0. wb_valid still asserts in that case.
  - wb_rd and wb_val are stable while wb_valid=1 and wb_ready=0.
  - When wb_valid and wb_ready are both 1: go to IDLE, increment retired_count (wraps 0xFFFFFFFF to 0), and drop wb_valid on the next cycle.
- flush has top priority in every state. The next state is IDLE, wb_valid falls next cycle, and no retire or illegal_op occurs. flush together with read_valid means the issue is ignored. flush together with wb_ready in RESULT means no retire.
- read_valid=1 while state != IDLE: ignored and protocol_err set. Exception: no error in a cycle where flush=1.
- In IDLE, unit_valid or unit_processing with read_valid=0 is ignored, no error.
- illegal_op and timeout are never asserted together with wb_valid.
- protocol_err clears only on reset.

Test Plan:
- Single-cycle op: read_valid with decode_rd=5 and unit_valid=0b0001, unit0 value 0x12345678, wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_val=0x12345678. The cycle after, wb_valid=0 and retired_count=1.
- Multi-cycle shift: read_valid with unit_processing=0b0100, then unit2 valid 3 cycles later with value 0x80000000, rd=7 -> exec_busy=1 throughout, wb_valid on the following cycle, wb_val=0x80000000.
- Backpressure: wb_ready=0 for 4 cycles in RESULT -> wb_valid, wb_rd and wb_val held constant, then retire on the first cycle wb_ready=1, retired_count incremented exactly once.
- Illegal and timeout: read_valid with no unit flags -> illegal_op pulse of exactly 1 cycle, state IDLE. Separately, BUSY with no valid for TIMEOUT_CYCLES=64 cycles -> timeout pulse, no wb_valid.
- Flush: flush in BUSY and again in RESULT with wb_ready=1 -> IDLE next cycle, wb_valid=0, retired_count unchanged.
- Protocol errors and reset: unit_valid=0b0110 at capture -> wb_val taken from unit1 and protocol_err=1. reset_n low mid-BUSY -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/execute_result_collect.sv
// Execute-stage result sink: tracks the instruction in flight, waits on
// multi-cycle units, registers one result and offers it to writeback.
module execute_result_collect #(
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      read_valid,
    input  logic [4:0]                decode_rd,
    input  logic [NUM_UNITS-1:0]      unit_processing,
    input  logic [NUM_UNITS-1:0]      unit_valid,
    input  logic [32*NUM_UNITS-1:0]   unit_rd_val,
    output logic                      exec_busy,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [4:0]                wb_rd,
    output logic [31:0]               wb_val,
    output logic                      illegal_op,
    output logic                      timeout,
    output logic                      protocol_err,
    output logic [31:0]               retired_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESULT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [4:0]  r_rd;
    logic [4:0]  w_rd_next;
    logic [31:0] r_val;
    logic [31:0] w_val_next;
    logic        r_illegal;
    logic        r_timeout;
    logic        r_perr;
    logic [31:0] r_retired;
    logic        w_illegal;
    logic        w_timeout;
    logic        w_perr_set;
    logic        w_retire;
    logic [31:0] w_win_val;
    logic        w_any_valid;
    logic        w_multi_valid;
    logic        w_any_proc;

    // Scan from the top down so the lowest-index valid unit overwrites last.
    always_comb begin
        w_win_val = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (unit_valid[i]) begin
                w_win_val = unit_rd_val[32*i +: 32];
            end
        end
    end

    assign w_any_valid   = |unit_valid;
    assign w_multi_valid = (unit_valid & (unit_valid - NUM_UNITS'(1))) != '0;
    assign w_any_proc    = |unit_processing;

    // The x0 zeroing is applied at capture so the held value is already final.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_rd_next  = r_rd;
        w_val_next = r_val;
        w_illegal  = 1'b0;
        w_timeout  = 1'b0;
        w_perr_set = 1'b0;
        w_retire   = 1'b0;
        if (flush) begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (read_valid) begin
                        w_rd_next = decode_rd;
                        if (w_any_valid) begin
                            w_val_next = (decode_rd == 5'd0) ? 32'd0 : w_win_val;
                            w_perr_set = w_multi_valid;
                            w_next     = S_RESULT;
                        end else if (w_any_proc) begin
                            w_cnt_next = '0;
                            w_next     = S_BUSY;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    w_perr_set = read_valid;
                    if (w_any_valid) begin
                        w_val_next = (r_rd == 5'd0) ? 32'd0 : w_win_val;
                        w_perr_set = read_valid | w_multi_valid;
                        w_next     = S_RESULT;
                    end else if (r_cnt == TO_LAST) begin
                        w_timeout = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                S_RESULT: begin
                    w_perr_set = read_valid;
                    if (wb_ready) begin
                        w_retire = 1'b1;
                        w_next   = S_IDLE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_val     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_perr    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_rd      <= w_rd_next;
            r_val     <= w_val_next;
            r_illegal <= w_illegal;
            r_timeout <= w_timeout;
            if (w_perr_set) begin
                r_perr <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign exec_busy     = (r_state != S_IDLE);
    assign wb_valid      = (r_state == S_RESULT);
    assign wb_rd         = r_rd;
    assign wb_val        = r_val;
    assign illegal_op    = r_illegal;
    assign timeout       = r_timeout;
    assign protocol_err  = r_perr;
    assign retired_count = r_retired;

endmodule
